traffic_safety_monitor: RTL
===========================

TRAFFIC_SAFETY_MONITOR -- requirements
Module: traffic_safety_monitor

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 32, meaning maximum consecutive cycles lights_in may stay unchanged.
REQ-002 SHALL have parameter BLINK_HALF, default 4, meaning cycles per on-phase and per off-phase of the fault flash.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port clr_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port lights_in  input  6  lamp pattern from the traffic controller, [5:3]=A{red,yellow,green}, [2:0]=B{red,yellow,green}.
REQ-006 SHALL have port fault_clr  input  1  single-cycle request to leave fault mode.
REQ-007 SHALL have port lights_out  output  6  registered, validated lamp drive, same encoding as lights_in.
REQ-008 SHALL have port fault  output  1  high while in FAULT state.
REQ-009 SHALL have port fault_code  output  2  sticky cause: 00 none, 01 pattern, 10 sequence, 11 watchdog.

Function
REQ-010 SHALL implement states RUN and FAULT; no other reachable states.
REQ-011 In RUN with a legal sample, lights_out SHALL equal lights_in of the previous cycle (latency 1).
REQ-012 A sample SHALL be a pattern fault if either 3-bit group is not one-hot, or both groups are non-red.
REQ-013 A sample SHALL be a sequence fault if either group transitions G->R, Y->G, or R->Y relative to the previous sample; holds and R->G, G->Y, Y->R are legal.
REQ-014 The hold counter SHALL clear when lights_in differs from the previous sample, otherwise increment, saturating; a watchdog fault SHALL occur when it reaches MAX_HOLD.
REQ-015 On any fault in RUN, next cycle: state=FAULT, fault=1, fault_code latched by priority pattern > sequence > watchdog; the illegal pattern SHALL never appear on lights_out.
REQ-016 In FAULT, lights_out SHALL alternate 6'b100100 (BLINK_HALF cycles, first phase) and 6'b000000 (BLINK_HALF cycles), repeating.
REQ-017 In FAULT, fault_clr=1 while lights_in==6'b100100 SHALL return to RUN next cycle: fault=0, fault_code=00, hold counter cleared, lights_out=6'b100100.
REQ-018 fault_clr SHALL be ignored in RUN, and in FAULT when lights_in is not all-red.
REQ-019 Further faults while in FAULT SHALL not change fault_code.
REQ-020 The previous-sample register SHALL update every cycle in both states.

Reset
REQ-021 While clr_n=0: state=RUN, lights_out=6'b100100, fault=0, fault_code=00, previous sample=6'b100100, hold and blink counters=0.
REQ-022 Reset asserted mid-flash SHALL take effect immediately, with no further flash phase.

Configuration
REQ-023 With SAFETY_SEQ_CHECK_EN defined, REQ-013 checking SHALL be compiled in.
REQ-024 Without SAFETY_SEQ_CHECK_EN, sequence faults SHALL never be raised and code 10 SHALL never appear; all other behaviour is unchanged.

Structure
REQ-025 Package traffic_pkg SHALL hold the lamp encodings (ALL_RED=6'b100100, ALL_OFF), the fault-code constants, and the RUN/FAULT state type.
REQ-026 The flash timing SHALL live in sub-module traffic_blink (enable in, phase out, BLINK_HALF parameter).

Verification
REQ-027 After reset, drive the cycle 100001,100010,100100,001100,010100,100100 with 16/4/4/16/4/4-cycle holds -> lights_out follows with 1-cycle latency, fault=0 throughout.
REQ-028 Drive 001001 (both green) -> next cycle fault=1, fault_code=01, lights_out=100100; 001001 never appears on lights_out.
REQ-029 Drive 100001 then 100100 (B green->red) with the macro defined -> fault_code=10; with the macro undefined -> no fault.
REQ-030 Hold 100001 for MAX_HOLD+1 samples -> fault_code=11 exactly when the hold counter reaches 32; with BLINK_HALF=4, lights_out shows 4 cycles 100100 then 4 cycles 000000, repeating.
REQ-031 In FAULT: pulse fault_clr with lights_in=100001 -> ignored; pulse it with lights_in=100100 -> next cycle fault=0, fault_code=00.
REQ-032 Assert clr_n=0 mid-flash off-phase -> lights_out=100100 immediately (asynchronous), fault=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp encodings, fault codes, FSM state type and
// lamp-pattern helper functions for the traffic safety monitor.
// Lamp word layout: [5:3] = A{red,yellow,green}, [2:0] = B{red,yellow,green}.
package traffic_pkg;

  localparam int unsigned LAMP_W  = 6;
  localparam int unsigned GROUP_W = 3;

  localparam logic [LAMP_W-1:0]  ALL_RED = 6'b100100;
  localparam logic [LAMP_W-1:0]  ALL_OFF = 6'b000000;

  localparam logic [GROUP_W-1:0] LAMP_R  = 3'b100;
  localparam logic [GROUP_W-1:0] LAMP_Y  = 3'b010;
  localparam logic [GROUP_W-1:0] LAMP_G  = 3'b001;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_PATTERN  = 2'b01,
    FC_SEQUENCE = 2'b10,
    FC_WATCHDOG = 2'b11
  } fault_code_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  // Exactly one lamp lit in a 3-lamp group.
  function automatic logic onehot3(input logic [GROUP_W-1:0] g);
    return (g == LAMP_R) || (g == LAMP_Y) || (g == LAMP_G);
  endfunction

  // Static pattern check: malformed group, or neither direction shows red.
  function automatic logic pattern_bad(input logic [LAMP_W-1:0] s);
    return !onehot3(s[5:3]) || !onehot3(s[2:0]) || (!s[5] && !s[2]);
  endfunction

  // Forbidden group transitions: G->R (skips yellow), Y->G, R->Y.
  function automatic logic step_bad(input logic [GROUP_W-1:0] prev,
                                    input logic [GROUP_W-1:0] cur);
    return ((prev == LAMP_G) && (cur == LAMP_R)) ||
           ((prev == LAMP_Y) && (cur == LAMP_G)) ||
           ((prev == LAMP_R) && (cur == LAMP_Y));
  endfunction

endpackage

// File: rtl/traffic_blink.sv
// traffic_blink: fault-flash phase generator.
// Ports: clk, clr_n (async active-low), enable_i (count while high, held at 0
// otherwise), phase_c (combinational: 1 when the NEXT cycle is an on-phase).
// The flash is BLINK_HALF cycles on followed by BLINK_HALF cycles off.
module traffic_blink #(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic enable_i,
  output logic phase_c
);

  localparam int unsigned PERIOD = 2 * BLINK_HALF;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_nxt;

  // Wrap-around position counter; phase looks one cycle ahead so the
  // caller can register the lamp drive without extra latency.
  always_comb begin
    cnt_nxt = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
    cnt_d   = enable_i ? cnt_nxt : '0;
    phase_c = (cnt_nxt < CNT_W'(BLINK_HALF));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_safety_monitor.sv
// traffic_safety_monitor: validates the lamp pattern from a traffic
// controller and forces an all-red flash when it misbehaves.
// Ports: clk, clr_n (async active-low), lights_in[5:0] (controller lamps),
// fault_clr (leave fault mode, honoured only with all-red input),
// lights_out[5:0] (registered lamp drive), fault (in FAULT state),
// fault_code[1:0] (sticky cause: 01 pattern, 10 sequence, 11 watchdog).
// Build option: define SAFETY_SEQ_CHECK_EN to enable transition checking.
module traffic_safety_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 32,
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [LAMP_W-1:0] lights_in,
  input  logic              fault_clr,
  output logic [LAMP_W-1:0] lights_out,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  state_e            state_q, state_d;
  fault_code_e       code_q,  code_d;
  logic [LAMP_W-1:0] lights_q, lights_d;
  logic [LAMP_W-1:0] prev_q;
  logic [HOLD_W-1:0] hold_q,  hold_d, hold_nxt;

  logic pat_bad_c;
  logic seq_bad_c;
  logic wdg_bad_c;
  logic phase_c;

  traffic_blink #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk      (clk),
    .clr_n    (clr_n),
    .enable_i (state_q == ST_FAULT),
    .phase_c  (phase_c)
  );

  // Hold counter: restarts on any change, saturates at MAX_HOLD.
  always_comb begin
    if (lights_in != prev_q) begin
      hold_nxt = '0;
    end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
      hold_nxt = hold_q;
    end else begin
      hold_nxt = hold_q + HOLD_W'(1);
    end
  end

  assign pat_bad_c = pattern_bad(lights_in);
  assign wdg_bad_c = (hold_nxt == HOLD_W'(MAX_HOLD));

`ifdef SAFETY_SEQ_CHECK_EN
  assign seq_bad_c = step_bad(prev_q[5:3], lights_in[5:3]) ||
                     step_bad(prev_q[2:0], lights_in[2:0]);
`else
  assign seq_bad_c = 1'b0;
`endif

  // Next-state and lamp-drive logic.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    lights_d = lights_q;
    hold_d   = hold_nxt;
    case (state_q)
      ST_RUN: begin
        if (pat_bad_c || seq_bad_c || wdg_bad_c) begin
          state_d  = ST_FAULT;
          lights_d = ALL_RED;
          if (pat_bad_c) begin
            code_d = FC_PATTERN;
          end else if (seq_bad_c) begin
            code_d = FC_SEQUENCE;
          end else begin
            code_d = FC_WATCHDOG;
          end
        end else begin
          lights_d = lights_in;
        end
      end
      ST_FAULT: begin
        if (fault_clr && (lights_in == ALL_RED)) begin
          state_d  = ST_RUN;
          code_d   = FC_NONE;
          lights_d = ALL_RED;
          hold_d   = '0;
        end else begin
          lights_d = phase_c ? ALL_RED : ALL_OFF;
        end
      end
      default: begin
        state_d  = ST_RUN;
        code_d   = FC_NONE;
        lights_d = ALL_RED;
        hold_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_RUN;
      code_q   <= FC_NONE;
      lights_q <= ALL_RED;
      prev_q   <= ALL_RED;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      lights_q <= lights_d;
      prev_q   <= lights_in;
      hold_q   <= hold_d;
    end
  end

  assign lights_out = lights_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

endmodule
